// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART byte width and drain FSM state encoding
package uart_pkg;

  localparam int BYTE_W = 8;

  // Shared with the RX-side FIFO so both drain engines decode identically.
  typedef enum logic [1:0] {
    DRAIN_IDLE   = 2'd0,
    DRAIN_STROBE = 2'd1,
    DRAIN_HOLD   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer/transmitter handshake bundle for the UART TX FIFO
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  import uart_pkg::*;

  logic              wr_strobe;
  logic [BYTE_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              ovf_clear;
  logic              tx_ready;
  logic              tx_strobe;
  logic [BYTE_W-1:0] tx_data;

  modport master (
    output wr_strobe, wr_data, ovf_clear, tx_ready,
    input  full, empty, count, overflow, tx_strobe, tx_data
  );

  modport slave (
    input  wr_strobe, wr_data, ovf_clear, tx_ready,
    output full, empty, count, overflow, tx_strobe, tx_data
  );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x byte register array, one synchronous write port, one async read port
module fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // No reset: stale contents are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding the UART transmitter with a 3-state drain engine
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow_q;
  logic              tx_strobe_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic [BYTE_W-1:0] rd_byte;
  drain_state_t      state;

  logic full;
  logic empty;
  logic push;
  logic drop;
  logic pop;

  // Flags come from count so a full ring never aliases to empty.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = bus.wr_strobe && !full;
  assign drop  = bus.wr_strobe && full;
  assign pop   = (state == DRAIN_IDLE) && !empty && bus.tx_ready;

  fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (rd_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      // A drop in the same cycle as a clear wins: the loss must stay visible.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // STROBE and HOLD give the transmitter time to drop tx_ready before it is sampled again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= DRAIN_IDLE;
      rd_ptr      <= '0;
      tx_strobe_q <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      tx_strobe_q <= 1'b0;
      case (state)
        DRAIN_IDLE: begin
          if (pop) begin
            tx_data_q   <= rd_byte;
            tx_strobe_q <= 1'b1;
            rd_ptr      <= rd_ptr + PTR_ONE;
            state       <= DRAIN_STROBE;
          end
        end
        DRAIN_STROBE: state <= DRAIN_HOLD;
        DRAIN_HOLD:   state <= DRAIN_IDLE;
        default:      state <= DRAIN_IDLE;
      endcase
    end
  end

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count;
  assign bus.overflow  = overflow_q;
  assign bus.tx_strobe = tx_strobe_q;
  assign bus.tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int FRAME  = 5;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q [$];
  int exp_count  = 0;
  int n_strobes  = 0;
  int bad_ready  = 0;
  int bad_consec = 0;
  int unexpected = 0;
  int tx_mode    = 0;
  int busy       = 0;
  int s0         = 0;
  int pushed     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: scoreboard pushes/pops, protocol watch, and the transmitter ready model.
  task automatic tick();
    logic       push_acc;
    logic       rdy_pre;
    logic       strobe_pre;
    logic [7:0] eb;
    push_acc   = bus.wr_strobe && (exp_count < DEPTH);
    rdy_pre    = bus.tx_ready;
    strobe_pre = bus.tx_strobe;
    if (push_acc) exp_q.push_back(bus.wr_data);
    @(posedge clk);
    #1;
    if (bus.tx_strobe) begin
      n_strobes++;
      if (!rdy_pre) bad_ready++;
      if (strobe_pre) bad_consec++;
      if (exp_q.size() == 0) begin
        unexpected++;
      end else begin
        eb = exp_q.pop_front();
        chk("tx_data_order", bus.tx_data, eb);
      end
      exp_count--;
    end
    if (push_acc) exp_count++;
    if (tx_mode == 1) begin
      if (strobe_pre) begin
        busy = FRAME;
        bus.tx_ready = 1'b0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) bus.tx_ready = 1'b1;
      end
    end else if (tx_mode == 2) begin
      bus.tx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_strobe = 1'b0;
    bus.wr_data   = 8'h00;
    bus.ovf_clear = 1'b0;
    bus.tx_ready  = 1'b0;
    reset_n       = 1'b0;
    #12;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_tx_strobe", bus.tx_strobe, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte latency
    bus.tx_ready  = 1'b1;
    bus.wr_data   = 8'hA5;
    bus.wr_strobe = 1'b1;
    tick();
    bus.wr_strobe = 1'b0;
    chk("t2_count_after_push", bus.count, 1);
    chk("t2_no_strobe_yet", bus.tx_strobe, 0);
    tick();
    chk("t2_strobe", bus.tx_strobe, 1);
    chk("t2_tx_data", bus.tx_data, 8'hA5);
    chk("t2_empty", bus.empty, 1);
    tick();
    chk("t2_strobe_one_cycle", bus.tx_strobe, 0);
    chk("t2_tx_data_stable", bus.tx_data, 8'hA5);
    tick();
    tick();

    // Burst against a transmitter ready model
    tx_mode = 1;
    busy    = 0;
    bus.tx_ready = 1'b1;
    s0 = n_strobes;
    for (int i = 0; i < 16; i++) begin
      bus.wr_data   = 8'(i);
      bus.wr_strobe = 1'b1;
      tick();
    end
    bus.wr_strobe = 1'b0;
    for (int k = 0; k < 300 && (exp_q.size() != 0 || busy != 0); k++) tick();
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_strobe_count", n_strobes - s0, 16);
    chk("t3_ready_respected", bad_ready, 0);
    chk("t3_no_back_to_back", bad_consec, 0);
    chk("t3_no_extra_bytes", unexpected, 0);
    chk("t3_count_zero", bus.count, 0);
    tick();
    tick();

    // Overflow with the transmitter stalled
    tx_mode = 0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.wr_data   = 8'(8'h30 + i);
      bus.wr_strobe = 1'b1;
      tick();
    end
    bus.wr_strobe = 1'b0;
    chk("t4_full", bus.full, 1);
    chk("t4_count", bus.count, 16);
    chk("t4_overflow", bus.overflow, 1);
    chk("t4_not_empty", bus.empty, 0);
    bus.ovf_clear = 1'b1;
    tick();
    bus.ovf_clear = 1'b0;
    chk("t4_ovf_cleared", bus.overflow, 0);
    bus.ovf_clear = 1'b1;
    bus.wr_data   = 8'h77;
    bus.wr_strobe = 1'b1;
    tick();
    bus.ovf_clear = 1'b0;
    bus.wr_strobe = 1'b0;
    chk("t4_clear_vs_drop", bus.overflow, 1);
    chk("t4_count_held", bus.count, 16);
    bus.ovf_clear = 1'b1;
    tick();
    bus.ovf_clear = 1'b0;
    chk("t4_ovf_cleared_again", bus.overflow, 0);

    // Pop and dropped push on the same edge while full
    bus.tx_ready  = 1'b1;
    bus.wr_data   = 8'hEE;
    bus.wr_strobe = 1'b1;
    tick();
    bus.wr_strobe = 1'b0;
    chk("t5_count", bus.count, 15);
    chk("t5_overflow", bus.overflow, 1);
    chk("t5_strobe", bus.tx_strobe, 1);
    chk("t5_first_byte", bus.tx_data, 8'h30);
    chk("t5_not_full", bus.full, 0);
    tx_mode = 1;
    busy    = 0;
    for (int k = 0; k < 400 && (exp_q.size() != 0 || busy != 0); k++) tick();
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_no_extra_bytes", unexpected, 0);
    chk("t5_ready_respected", bad_ready, 0);
    chk("t5_no_back_to_back", bad_consec, 0);
    bus.ovf_clear = 1'b1;
    tick();
    bus.ovf_clear = 1'b0;
    tick();
    tick();

    // Pointer wrap with random transmitter readiness
    tx_mode = 2;
    s0 = n_strobes;
    pushed = 0;
    for (int k = 0; k < 1500 && (pushed < 40 || exp_q.size() != 0); k++) begin
      if (pushed < 40 && exp_count < DEPTH && $urandom_range(0, 3) != 0) begin
        bus.wr_strobe = 1'b1;
        bus.wr_data   = 8'(128 + pushed * 3);
        pushed++;
      end else begin
        bus.wr_strobe = 1'b0;
      end
      tick();
      chk("t6_count_vs_scoreboard", bus.count, exp_count);
    end
    bus.wr_strobe = 1'b0;
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_strobe_count", n_strobes - s0, 40);
    chk("t6_no_extra_bytes", unexpected, 0);
    chk("t6_ready_respected", bad_ready, 0);
    chk("t6_no_back_to_back", bad_consec, 0);

    // Asynchronous reset in the middle of activity
    tx_mode = 0;
    bus.tx_ready = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 18; i++) begin
      bus.wr_data   = 8'(8'h10 + i);
      bus.wr_strobe = 1'b1;
      tick();
    end
    bus.wr_strobe = 1'b0;
    bus.tx_ready  = 1'b1;
    tick();
    bus.tx_ready  = 1'b0;
    chk("t1_strobe_before_reset", bus.tx_strobe, 1);
    reset_n = 1'b0;
    #1;
    chk("t1_count", bus.count, 0);
    chk("t1_empty", bus.empty, 1);
    chk("t1_full", bus.full, 0);
    chk("t1_overflow", bus.overflow, 0);
    chk("t1_tx_strobe", bus.tx_strobe, 0);
    chk("t1_tx_data", bus.tx_data, 8'h00);
    exp_q.delete();
    exp_count = 0;
    #2;
    reset_n = 1'b1;
    bus.wr_data   = 8'h5A;
    bus.wr_strobe = 1'b1;
    tick();
    bus.wr_strobe = 1'b0;
    chk("t1_push_after_reset", bus.count, 1);
    chk("t1_not_empty", bus.empty, 0);
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("t1_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
